// File: rtl/io_pad_halfduplex_ctrl.sv
// ---------------------------------------------------------------------------
// io_pad_halfduplex_ctrl
//
// Drives one bidirectional CMOS pad as a half-duplex serial line. Each word
// taken on the tx_valid/tx_ready port is sent as a lead '1' bit followed by
// the word MSB-first, BIT_CYC clocks per bit. After the last bit the pad is
// released for TURN_CYC clocks before a new word is accepted. While idle,
// the pad is released and the pull-up is enabled. The pad input is
// synchronised and returned to the core. During the drive the synchronised
// readback is compared against the driven bit to detect bus collisions.
//
// Ports
//   clk, rst            core clock, asynchronous active-high reset
//   tx_valid/tx_ready   word handshake, tx_data is W bits, sent MSB first
//   ds_cfg              drive strength to use while driving
//   tx_done, tx_abort   one-cycle completion pulse; abort flag valid with it
//   err_coll, err_clr   sticky collision flag and its clear
//   rx_z, rx_qual       synchronised pad input; qualifier (not driving, not turning)
//   pad_a/oen/ds/pen/ud registered pad controls
//   pad_z               raw pad input (asynchronous)
// ---------------------------------------------------------------------------
module io_pad_halfduplex_ctrl #(
    parameter int W             = 8,
    parameter int BIT_CYC       = 4,
    parameter int TURN_CYC      = 2,
    parameter int ABORT_ON_COLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tx_valid,
    output logic         tx_ready,
    input  logic [W-1:0] tx_data,
    input  logic         ds_cfg,
    output logic         tx_done,
    output logic         tx_abort,
    output logic         err_coll,
    input  logic         err_clr,
    output logic         rx_z,
    output logic         rx_qual,
    output logic         pad_a,
    output logic         pad_oen,
    output logic         pad_ds,
    output logic         pad_pen,
    output logic         pad_ud,
    input  logic         pad_z
);

    localparam int  CW    = (BIT_CYC  > 1) ? $clog2(BIT_CYC)  : 1;
    localparam int  BW    = (W        > 1) ? $clog2(W)        : 1;
    localparam int  TW    = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    localparam bit  ABORT = (ABORT_ON_COLL != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_TURN
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cyc_reg;
    logic [BW-1:0]   bit_reg;
    logic [TW-1:0]   turn_reg;
    logic [W-1:0]    shift_reg;
    logic [1:0]      sync_reg;
    logic            abort_pend_reg;
    logic            tx_ready_reg;
    logic            tx_done_reg;
    logic            tx_abort_reg;
    logic            err_coll_reg;
    logic            rx_qual_reg;
    logic            pad_a_reg;
    logic            pad_oen_reg;
    logic            pad_ds_reg;
    logic            pad_pen_reg;
    logic            pad_ud_reg;

    logic            bit_end;
    logic            coll_now;
    logic            abort_now;

    // Last cycle of a bit period: the readback has had BIT_CYC-1 cycles to
    // settle through the synchroniser, so it reflects this period's bit.
    assign bit_end   = (cyc_reg == CW'(BIT_CYC - 1));
    // pad_a_reg is the bit currently on the pad, so it is the reference.
    assign coll_now  = ((state_reg == ST_LEAD) || (state_reg == ST_SHIFT)) &&
                       bit_end && (sync_reg[1] != pad_a_reg);
    assign abort_now = coll_now && ABORT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cyc_reg        <= '0;
            bit_reg        <= '0;
            turn_reg       <= '0;
            shift_reg      <= '0;
            sync_reg       <= 2'b11;
            abort_pend_reg <= 1'b0;
            tx_ready_reg   <= 1'b1;
            tx_done_reg    <= 1'b0;
            tx_abort_reg   <= 1'b0;
            err_coll_reg   <= 1'b0;
            rx_qual_reg    <= 1'b0;
            pad_a_reg      <= 1'b1;
            pad_oen_reg    <= 1'b0;
            pad_ds_reg     <= 1'b0;
            pad_pen_reg    <= 1'b1;
            pad_ud_reg     <= 1'b1;
        end else begin
            sync_reg     <= {sync_reg[0], pad_z};
            pad_ud_reg   <= 1'b1;
            tx_done_reg  <= 1'b0;
            tx_abort_reg <= 1'b0;

            // Set has priority over clear so a collision is never lost.
            if (coll_now) begin
                err_coll_reg <= 1'b1;
            end else if (err_clr) begin
                err_coll_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    rx_qual_reg <= 1'b1;
                    if (tx_valid) begin
                        shift_reg      <= tx_data;
                        state_reg      <= ST_LEAD;
                        cyc_reg        <= '0;
                        abort_pend_reg <= 1'b0;
                        tx_ready_reg   <= 1'b0;
                        rx_qual_reg    <= 1'b0;
                        pad_oen_reg    <= 1'b1;
                        pad_pen_reg    <= 1'b0;
                        pad_ds_reg     <= ds_cfg;
                        pad_a_reg      <= 1'b1;
                    end
                end

                ST_LEAD, ST_SHIFT: begin
                    pad_ds_reg <= ds_cfg;
                    if (!bit_end) begin
                        cyc_reg <= cyc_reg + 1'b1;
                    end else begin
                        cyc_reg <= '0;
                        if (abort_now || ((state_reg == ST_SHIFT) && (bit_reg == '0))) begin
                            state_reg      <= ST_TURN;
                            turn_reg       <= '0;
                            abort_pend_reg <= abort_now;
                            pad_oen_reg    <= 1'b0;
                            pad_pen_reg    <= 1'b1;
                            pad_ds_reg     <= 1'b0;
                            pad_a_reg      <= 1'b1;
                        end else begin
                            // Next bit always comes from the top of the
                            // shift register; the lead period loads bit W-1.
                            if (state_reg == ST_LEAD) begin
                                bit_reg <= BW'(W - 1);
                            end else begin
                                bit_reg <= bit_reg - 1'b1;
                            end
                            state_reg <= ST_SHIFT;
                            pad_a_reg <= shift_reg[W-1];
                            shift_reg <= shift_reg << 1;
                        end
                    end
                end

                ST_TURN: begin
                    if (turn_reg == TW'(TURN_CYC - 1)) begin
                        state_reg    <= ST_IDLE;
                        turn_reg     <= '0;
                        tx_done_reg  <= 1'b1;
                        tx_abort_reg <= abort_pend_reg;
                        tx_ready_reg <= 1'b1;
                        rx_qual_reg  <= 1'b1;
                    end else begin
                        turn_reg <= turn_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // The ready register is already 1 in reset; hold it off until reset drops.
    assign tx_ready = tx_ready_reg & ~rst;
    assign tx_done  = tx_done_reg;
    assign tx_abort = tx_abort_reg;
    assign err_coll = err_coll_reg;
    assign rx_z     = sync_reg[1];
    assign rx_qual  = rx_qual_reg;
    assign pad_a    = pad_a_reg;
    assign pad_oen  = pad_oen_reg;
    assign pad_ds   = pad_ds_reg;
    assign pad_pen  = pad_pen_reg;
    assign pad_ud   = pad_ud_reg;

endmodule

// File: tb/tb_io_pad_halfduplex_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for io_pad_halfduplex_ctrl.
// Instance u_dut_a uses ABORT_ON_COLL=1, u_dut_b uses ABORT_ON_COLL=0; both
// share the transmit inputs. Pads loop back with a pull-up unless forced.
// Stimulus pushes the expected word record into exp_q; a monitor collects the
// driven pattern and compares it when tx_done appears on u_dut_a.
// ---------------------------------------------------------------------------
module tb_io_pad_halfduplex_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tx_valid = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         ds_cfg = 1'b0;
    logic         err_clr = 1'b0;
    logic         force_en = 1'b0;
    logic         force_val = 1'b1;

    logic ready_a, done_a, abort_a, err_a, rxz_a, rxq_a, pa_a, oen_a, ds_a, pen_a, ud_a, pz_a;
    logic ready_b, done_b, abort_b, err_b, rxz_b, rxq_b, pa_b, oen_b, ds_b, pen_b, ud_b, pz_b;

    assign pz_a = force_en ? force_val : (oen_a ? pa_a : 1'b1);
    assign pz_b = force_en ? force_val : (oen_b ? pa_b : 1'b1);

    io_pad_halfduplex_ctrl #(.W(W), .BIT_CYC(4), .TURN_CYC(2), .ABORT_ON_COLL(1)) u_dut_a (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(ready_a), .tx_data(tx_data),
        .ds_cfg(ds_cfg), .tx_done(done_a), .tx_abort(abort_a), .err_coll(err_a),
        .err_clr(err_clr), .rx_z(rxz_a), .rx_qual(rxq_a), .pad_a(pa_a), .pad_oen(oen_a),
        .pad_ds(ds_a), .pad_pen(pen_a), .pad_ud(ud_a), .pad_z(pz_a)
    );

    io_pad_halfduplex_ctrl #(.W(W), .BIT_CYC(4), .TURN_CYC(2), .ABORT_ON_COLL(0)) u_dut_b (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(ready_b), .tx_data(tx_data),
        .ds_cfg(ds_cfg), .tx_done(done_b), .tx_abort(abort_b), .err_coll(err_b),
        .err_clr(err_clr), .rx_z(rxz_b), .rx_qual(rxq_b), .pad_a(pa_b), .pad_oen(oen_b),
        .pad_ds(ds_b), .pad_pen(pen_b), .pad_ud(ud_b), .pad_z(pz_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [63:0] bits;
        int          len;
        logic        abort;
        int          lat;
        logic        err;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Inputs change and direct checks happen 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [63:0] bits, input int len, input logic abort,
                            input int lat, input logic err, input string name);
        exp_t e;
        e.bits = bits; e.len = len; e.abort = abort; e.lat = lat; e.err = err; e.name = name;
        exp_q.push_back(e);
    endtask

    // Present a word and wait (bounded) until it is taken; returns the
    // cycle number of the accepting cycle.
    task automatic start_word(input logic [W-1:0] data, output int acc_cyc);
        int t;
        tx_data  = data;
        tx_valid = 1'b1;
        t = 0;
        while (!ready_a && t < 100) begin
            tick();
            t++;
        end
        check("accept_wait", {63'd0, ready_a}, 64'd1);
        acc_cyc = cyc;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!(ready_a && ready_b) && t < 100) begin
            tick();
            t++;
        end
        check("idle_wait", {62'd0, ready_a, ready_b}, 64'd3);
        tick();
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [63:0] drv_bits;
        int          drv_len;
        int          turn_run;
        logic        ds_bad;
        exp_t        e;
        int          a;
        drv_bits = '0; drv_len = 0; turn_run = 0; ds_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc_q.delete();
            end else begin
                if (done_a) begin
                    if (exp_q.size() == 0 || acc_q.size() == 0) begin
                        check("unexpected_tx_done", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        check({e.name, "_latency"}, 64'(cyc - a), 64'(e.lat));
                        check({e.name, "_abort"}, {63'd0, abort_a}, {63'd0, e.abort});
                        check({e.name, "_err"}, {63'd0, err_a}, {63'd0, e.err});
                        check({e.name, "_drv_len"}, 64'(drv_len), 64'(e.len));
                        check({e.name, "_drv_bits"}, drv_bits & ((64'd1 << drv_len) - 64'd1), e.bits);
                        check({e.name, "_turn_cycles"}, 64'(turn_run), 64'd2);
                        check({e.name, "_ds"}, {63'd0, ds_bad}, 64'd0);
                    end
                end
                if (tx_valid && ready_a) begin
                    acc_q.push_back(cyc);
                    drv_bits = '0; drv_len = 0; turn_run = 0; ds_bad = 1'b0;
                end
                if (oen_a) begin
                    drv_bits = {drv_bits[62:0], pa_a};
                    drv_len++;
                    if (pen_a !== 1'b0) ds_bad = 1'b1;
                end
                if (!oen_a && !rxq_a) turn_run++;
                if (ds_a !== (oen_a ? ds_cfg : 1'b0)) ds_bad = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int k2;
        int t;
        int drv_b;

        // Reset state
        repeat (3) tick();
        check("rst_oen", {63'd0, oen_a}, 64'd0);
        check("rst_a", {63'd0, pa_a}, 64'd1);
        check("rst_ds", {63'd0, ds_a}, 64'd0);
        check("rst_pen_ud", {62'd0, pen_a, ud_a}, 64'd3);
        check("rst_done_abort_err", {61'd0, done_a, abort_a, err_a}, 64'd0);
        check("rst_rx_qual", {63'd0, rxq_a}, 64'd0);
        check("rst_rx_z", {63'd0, rxz_a}, 64'd1);
        rst = 1'b0;
        #1;
        check("rst_release_ready", {63'd0, ready_a}, 64'd1);
        tick();
        tick();
        check("idle_rx_qual", {63'd0, rxq_a}, 64'd1);

        // Receive path: pad_z 1 -> 0 -> 1 with 2 cycles of latency
        force_en = 1'b1; force_val = 1'b0;
        tick();
        check("rx_fall_lat1", {62'd0, rxz_a, rxq_a}, 64'd3);
        tick();
        check("rx_fall_lat2", {62'd0, rxz_a, rxq_a}, 64'd1);
        force_val = 1'b1;
        tick();
        check("rx_rise_lat1", {63'd0, rxz_a}, 64'd0);
        tick();
        check("rx_rise_lat2", {62'd0, rxz_a, rxq_a}, 64'd3);
        force_en = 1'b0;
        tick();

        // Single word 8'hA5 with strong drive
        ds_cfg = 1'b1;
        push_exp(64'hF_F0F0_0F0F, 36, 1'b0, 39, 1'b0, "a5");
        start_word(8'hA5, k);
        tick();
        tx_valid = 1'b0;
        while (cyc < k + 36) tick();
        check("a5_oen_c36", {63'd0, oen_a}, 64'd1);
        tick();
        check("a5_oen_rxq_c37", {62'd0, oen_a, rxq_a}, 64'd0);
        tick();
        check("a5_rxq_c38", {63'd0, rxq_a}, 64'd0);
        wait_idle();

        // Back-to-back 8'h00 then 8'hFF, weak drive
        ds_cfg = 1'b0;
        push_exp(64'hF_0000_0000, 36, 1'b0, 39, 1'b0, "w00");
        push_exp(64'hF_FFFF_FFFF, 36, 1'b0, 39, 1'b0, "wff");
        start_word(8'h00, k);
        tick();
        tx_data = 8'hFF;
        t = 0;
        while (!ready_a && t < 100) begin
            tick();
            t++;
        end
        check("b2b_second_accept_cycle", 64'(cyc - k), 64'd39);
        check("b2b_accept_with_done", {63'd0, done_a}, 64'd1);
        tick();
        tx_valid = 1'b0;
        wait_idle();

        // Collision on bit 6 of 8'hC0: u_dut_a aborts, u_dut_b completes
        ds_cfg = 1'b1;
        push_exp(64'hFFF, 12, 1'b1, 15, 1'b1, "c0_abort");
        start_word(8'hC0, k);
        drv_b = 0;
        k2 = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 1) tx_valid = 1'b0;
            if (i == 9) begin force_en = 1'b1; force_val = 1'b0; end
            if (i == 12) check("coll_err_before_end", {63'd0, err_a}, 64'd0);
            if (i == 13) begin
                force_en = 1'b0;
                check("coll_err_set", {62'd0, err_a, err_b}, 64'd3);
                check("coll_turn_oen", {63'd0, oen_a}, 64'd0);
            end
            if (oen_b) drv_b++;
            if (done_b) begin
                k2 = cyc - k;
                check("noabort_abort", {63'd0, abort_b}, 64'd0);
                check("noabort_err", {63'd0, err_b}, 64'd1);
                break;
            end
        end
        check("noabort_latency", 64'(k2), 64'd39);
        check("noabort_drive_cycles", 64'(drv_b), 64'd36);
        wait_idle();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", {62'd0, err_a, err_b}, 64'd0);

        // Reset in mid-SHIFT: pad released at once, no tx_done afterwards
        start_word(8'h5A, k);
        tick();
        tx_valid = 1'b0;
        repeat (10) tick();
        check("mid_shift_oen", {63'd0, oen_a}, 64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_pads", {60'd0, oen_a, pen_a, ud_a, pa_a}, 64'h7);
        check("async_rst_oen_b", {63'd0, oen_b}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_ready", {63'd0, ready_a}, 64'd1);
        repeat (45) tick();
        check("post_rst_no_pending", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
